// File: rtl/axis_hdr_insert_if.sv
// Stream, header and output handshake bundle for the header-insert/pack block.
// The slave view belongs to the block; the master view drives it.
interface axis_hdr_insert_pack_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD + 1)
) ();
    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;
    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;
    logic                    valid_insert;
    logic                    ready_insert;
    logic [DATA_WD-1:0]      data_insert;
    logic [DATA_BYTE_WD-1:0] keep_insert;
    logic [BYTE_CNT_WD-1:0]  byte_insert_cnt;

    modport slave (
        input  valid_in, data_in, keep_in, last_in, ready_out,
        input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
        output ready_in, valid_out, data_out, keep_out, last_out, ready_insert
    );

    modport master (
        output valid_in, data_in, keep_in, last_in, ready_out,
        output valid_insert, data_insert, keep_insert, byte_insert_cnt,
        input  ready_in, valid_out, data_out, keep_out, last_out, ready_insert
    );
endinterface

// File: rtl/axis_hdr_insert_pack.sv
// Prepends a 0..W byte header to each AXI-stream packet and repacks the bytes
// into full MSB-aligned beats, emitting a trailing flush beat when bytes spill over.
module axis_hdr_insert_pack #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axis_hdr_insert_pack_if.slave bus,
    output logic                  hdr_err,
    output logic [15:0]           pkt_cnt
);
    localparam int W      = DATA_BYTE_WD;
    localparam int SUM_WD = BYTE_CNT_WD + 1;
    localparam logic [BYTE_CNT_WD-1:0] W_CNT = BYTE_CNT_WD'(W);
    localparam logic [SUM_WD-1:0]      W_SUM = SUM_WD'(W);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    function automatic logic [BYTE_CNT_WD-1:0] ones_count(input logic [W-1:0] v);
        logic [BYTE_CNT_WD-1:0] cnt;
        cnt = {BYTE_CNT_WD{1'b0}};
        for (int i = 0; i < W; i++) begin
            cnt = cnt + {{(BYTE_CNT_WD-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    function automatic logic [W-1:0] top_mask(input logic [SUM_WD-1:0] k);
        return ~({W{1'b1}} >> k);
    endfunction

    function automatic logic [DATA_WD-1:0] byte_expand(input logic [W-1:0] k);
        logic [DATA_WD-1:0] m;
        m = {DATA_WD{1'b0}};
        for (int i = 0; i < W; i++) begin
            m[i*8 +: 8] = {8{k[i]}};
        end
        return m;
    endfunction

    logic [1:0]             state_r, state_nxt_s;
    logic [DATA_WD-1:0]     res_r, res_nxt_s;
    logic [BYTE_CNT_WD-1:0] res_cnt_r, res_cnt_nxt_s;
    logic                   valid_out_r, last_out_r, hdr_err_r;
    logic [DATA_WD-1:0]     data_out_r;
    logic [W-1:0]           keep_out_r;
    logic [15:0]            pkt_cnt_r;

    logic                   adv_s, in_fire_s, hdr_fire_s, load_s, ld_last_s, hdr_bad_s;
    logic [BYTE_CNT_WD-1:0] n_s, h_s, hdr_shift_s;
    logic [SUM_WD-1:0]      sum_s;
    logic [2*DATA_WD-1:0]   stream_s;
    logic [DATA_WD-1:0]     hdr_data_s, ld_data_s;
    logic [W-1:0]           hdr_keep_exp_s, ld_keep_s;

    assign adv_s      = !valid_out_r || bus.ready_out;
    assign in_fire_s  = bus.valid_in && (state_r == ST_STREAM) && adv_s;
    assign hdr_fire_s = bus.valid_insert && (state_r == ST_IDLE);
    assign n_s        = ones_count(bus.keep_in);
    assign sum_s      = {1'b0, res_cnt_r} + {1'b0, n_s};
    // Residue sits MSB-aligned with zero tail, so OR-ing in the shifted masked input builds S.
    assign stream_s   = {res_r, {DATA_WD{1'b0}}}
                      | ({bus.data_in & byte_expand(bus.keep_in), {DATA_WD{1'b0}}} >> {res_cnt_r, 3'b000});

    assign h_s            = (bus.byte_insert_cnt > W_CNT) ? W_CNT : bus.byte_insert_cnt;
    assign hdr_shift_s    = W_CNT - h_s;
    assign hdr_data_s     = bus.data_insert << {hdr_shift_s, 3'b000};
    assign hdr_keep_exp_s = ~({W{1'b1}} << h_s);
    assign hdr_bad_s      = (bus.byte_insert_cnt > W_CNT) || (bus.keep_insert != hdr_keep_exp_s);

    // Next-state, residue update and output-register load selection.
    always_comb begin
        state_nxt_s   = state_r;
        res_nxt_s     = res_r;
        res_cnt_nxt_s = res_cnt_r;
        load_s        = 1'b0;
        ld_data_s     = {DATA_WD{1'b0}};
        ld_keep_s     = {W{1'b0}};
        ld_last_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hdr_fire_s) begin
                    res_nxt_s     = hdr_data_s;
                    res_cnt_nxt_s = h_s;
                    state_nxt_s   = ST_STREAM;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (in_fire_s) begin
                    load_s    = 1'b1;
                    ld_data_s = stream_s[2*DATA_WD-1 -: DATA_WD];
                    if (sum_s >= W_SUM) begin
                        ld_keep_s     = {W{1'b1}};
                        res_nxt_s     = stream_s[DATA_WD-1:0];
                        res_cnt_nxt_s = BYTE_CNT_WD'(sum_s - W_SUM);
                    end else begin
                        ld_keep_s     = top_mask(sum_s);
                        res_nxt_s     = {DATA_WD{1'b0}};
                        res_cnt_nxt_s = {BYTE_CNT_WD{1'b0}};
                    end
                    if (bus.last_in && (sum_s > W_SUM)) begin
                        state_nxt_s = ST_FLUSH;
                    end else if (bus.last_in) begin
                        ld_last_s     = 1'b1;
                        res_nxt_s     = {DATA_WD{1'b0}};
                        res_cnt_nxt_s = {BYTE_CNT_WD{1'b0}};
                        state_nxt_s   = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_STREAM;
                    end
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            ST_FLUSH: begin
                if (adv_s) begin
                    load_s        = 1'b1;
                    ld_data_s     = res_r;
                    ld_keep_s     = top_mask({1'b0, res_cnt_r});
                    ld_last_s     = 1'b1;
                    res_nxt_s     = {DATA_WD{1'b0}};
                    res_cnt_nxt_s = {BYTE_CNT_WD{1'b0}};
                    state_nxt_s   = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            default: begin
                res_nxt_s     = {DATA_WD{1'b0}};
                res_cnt_nxt_s = {BYTE_CNT_WD{1'b0}};
                state_nxt_s   = ST_IDLE;
            end
        endcase
    end

    // Control state and pending residue bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            res_r     <= {DATA_WD{1'b0}};
            res_cnt_r <= {BYTE_CNT_WD{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            res_r     <= res_nxt_s;
            res_cnt_r <= res_cnt_nxt_s;
        end
    end

    // Output register: holds while stalled, valid drops only on an unrefilled handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out_r <= 1'b0;
            data_out_r  <= {DATA_WD{1'b0}};
            keep_out_r  <= {W{1'b0}};
            last_out_r  <= 1'b0;
        end else if (load_s) begin
            valid_out_r <= 1'b1;
            data_out_r  <= ld_data_s;
            keep_out_r  <= ld_keep_s;
            last_out_r  <= ld_last_s;
        end else if (bus.ready_out) begin
            valid_out_r <= 1'b0;
        end
    end

    // Sticky header error and completed-packet counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_err_r <= 1'b0;
            pkt_cnt_r <= 16'd0;
        end else begin
            if (hdr_fire_s && hdr_bad_s) begin
                hdr_err_r <= 1'b1;
            end
            if (valid_out_r && bus.ready_out && last_out_r) begin
                pkt_cnt_r <= pkt_cnt_r + 16'd1;
            end
        end
    end

    assign bus.ready_in     = (state_r == ST_STREAM) && adv_s;
    assign bus.ready_insert = (state_r == ST_IDLE);
    assign bus.valid_out    = valid_out_r;
    assign bus.data_out     = data_out_r;
    assign bus.keep_out     = keep_out_r;
    assign bus.last_out     = last_out_r;
    assign hdr_err          = hdr_err_r;
    assign pkt_cnt          = pkt_cnt_r;
endmodule

// File: tb/tb_axis_hdr_insert_pack.sv
// Randomized bench for axis_hdr_insert_pack: a byte-queue reference model predicts
// every output beat, and directed cases cover the worked examples and reset.
module tb_axis_hdr_insert_pack;
    localparam int DW = 32;
    localparam int CW = 3;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hdr_err;
    logic [15:0] pkt_cnt;

    axis_hdr_insert_pack_if #(.DATA_WD(DW)) bus ();

    axis_hdr_insert_pack #(.DATA_WD(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .hdr_err (hdr_err),
        .pkt_cnt (pkt_cnt)
    );

    always #5 clk = ~clk;

    beat_t       exp_q[$];
    logic [31:0] pw_data[$];
    logic [3:0]  pw_keep[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_pkts = 0;
    logic        exp_hdr_err = 1'b0;
    int          bp_mode = 0;
    int          beats_acc = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Downstream readiness: always ready, random backpressure, or forced stall.
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            1:       bus.ready_out = ($urandom_range(0, 3) != 0);
            2:       bus.ready_out = 1'b0;
            default: bus.ready_out = 1'b1;
        endcase
    end

    // Scoreboard: every output handshake must match the next predicted beat.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.valid_out === 1'b1 && bus.ready_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("extra_beat", {63'd0, bus.valid_out}, 64'd0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check_val("data_out", {32'd0, bus.data_out}, {32'd0, e.d});
                check_val("keep_out", {60'd0, bus.keep_out}, {60'd0, e.k});
                check_val("last_out", {63'd0, bus.last_out}, {63'd0, e.l});
                if (e.l) exp_pkts++;
            end
        end
    end

    function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k, input logic l);
        beat_t b;
        b.d = d; b.k = k; b.l = l;
        return b;
    endfunction

    // Reference: header bytes then payload bytes, cut into 4-byte beats.
    task automatic model_push(input int heff, input logic [31:0] hd);
        logic [7:0] bq[$];
        int         n, nbeats, idx, last_n;
        logic [31:0] d;
        logic [3:0]  k;
        bit          null_beat;
        for (int j = 0; j < heff; j++) bq.push_back(hd[(heff-1-j)*8 +: 8]);
        for (int i = 0; i < pw_data.size(); i++) begin
            n = $countones(pw_keep[i]);
            for (int b = 0; b < n; b++) bq.push_back(pw_data[i][31-8*b -: 8]);
        end
        last_n    = $countones(pw_keep[pw_keep.size()-1]);
        null_beat = (heff == 0) && (last_n == 0);
        nbeats    = (bq.size() + 3) / 4;
        for (int b = 0; b < nbeats; b++) begin
            d = 32'd0; k = 4'd0;
            for (int s = 0; s < 4; s++) begin
                idx = b * 4 + s;
                if (idx < bq.size()) begin
                    d[31-8*s -: 8] = bq[idx];
                    k[3-s] = 1'b1;
                end
            end
            exp_q.push_back(mk(d, k, (b == nbeats - 1) && !null_beat));
        end
        if (null_beat) exp_q.push_back(mk(32'd0, 4'd0, 1'b1));
    endtask

    task automatic send_header(input logic [CW-1:0] h, input logic [31:0] hd, input logic [3:0] hk);
        int heff;
        bit ok;
        heff = (h > 3'd4) ? 4 : int'(h);
        bus.valid_insert    = 1'b1;
        bus.byte_insert_cnt = h;
        bus.data_insert     = hd;
        bus.keep_insert     = hk;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.ready_insert) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
        end
        bus.valid_insert = 1'b0;
        if (!ok) check_val("hdr_timeout", {63'd0, bus.ready_insert}, 64'd1);
        else if ((h > 3'd4) || (hk != 4'((1 << heff) - 1))) exp_hdr_err = 1'b1;
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        bit ok;
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        bus.keep_in  = k;
        bus.last_in  = l;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.ready_in) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
        end
        beats_acc++;
        if (!ok) check_val("in_timeout", {63'd0, bus.ready_in}, 64'd1);
    endtask

    task automatic run_packet(input logic [CW-1:0] h, input logic [31:0] hd, input logic [3:0] hk,
                              input bit use_model);
        if (use_model) model_push((h > 3'd4) ? 4 : int'(h), hd);
        send_header(h, hd, hk);
        for (int i = 0; i < pw_data.size(); i++) begin
            drive_beat(pw_data[i], pw_keep[i], i == pw_data.size() - 1);
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic gen_payload(input int nbeats, input bit allow_empty_last);
        int n;
        logic [3:0] k;
        pw_data.delete();
        pw_keep.delete();
        for (int i = 0; i < nbeats; i++) begin
            pw_data.push_back($urandom);
            if (i == nbeats - 1) begin
                n = allow_empty_last ? $urandom_range(0, 4) : $urandom_range(1, 4);
                k = 4'hF;
                k = k << (4 - n);
                pw_keep.push_back(k);
            end else begin
                pw_keep.push_back(4'hF);
            end
        end
    endtask

    task automatic random_packet();
        int h;
        h = $urandom_range(0, 4);
        gen_payload($urandom_range(1, 4), ($urandom_range(0, 4) == 0));
        run_packet(CW'(h), $urandom, 4'((1 << h) - 1), 1'b1);
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        repeat (2) @(posedge clk);
        #1;
        check_val({tag, "_left"}, 64'(exp_q.size()), 64'd0);
        check_val({tag, "_pkt_cnt"}, {48'd0, pkt_cnt}, 64'(exp_pkts));
        check_val({tag, "_hdr_err"}, {63'd0, hdr_err}, {63'd0, exp_hdr_err});
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_val("rst_valid_out", {63'd0, bus.valid_out}, 64'd0);
        check_val("rst_data_out", {32'd0, bus.data_out}, 64'd0);
        check_val("rst_keep_out", {60'd0, bus.keep_out}, 64'd0);
        check_val("rst_last_out", {63'd0, bus.last_out}, 64'd0);
        check_val("rst_hdr_err", {63'd0, hdr_err}, 64'd0);
        check_val("rst_pkt_cnt", {48'd0, pkt_cnt}, 64'd0);
        exp_q.delete();
        exp_pkts     = 0;
        exp_hdr_err  = 1'b0;
        bus.valid_in = 1'b0;
        bus.valid_insert = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_val("rst_ready_insert", {63'd0, bus.ready_insert}, 64'd1);
    endtask

    initial begin
        bus.valid_in = 1'b0; bus.data_in = 32'd0; bus.keep_in = 4'd0; bus.last_in = 1'b0;
        bus.valid_insert = 1'b0; bus.data_insert = 32'd0; bus.keep_insert = 4'd0;
        bus.byte_insert_cnt = 3'd0;
        rst_n = 1'b1;
        #2;
        apply_reset();

        // Two-beat packet with a 2-byte header spilling into a flush beat.
        pw_data = '{32'h11223344, 32'h55667788};
        pw_keep = '{4'hF, 4'hF};
        exp_q.push_back(mk(32'hAABB1122, 4'hF, 1'b0));
        exp_q.push_back(mk(32'h33445566, 4'hF, 1'b0));
        exp_q.push_back(mk(32'h77880000, 4'hC, 1'b1));
        run_packet(3'd2, 32'h0000AABB, 4'b0011, 1'b0);
        drain("ex040");

        // Single-byte beat completes a 3-byte header into one full last beat.
        pw_data = '{32'h99000000};
        pw_keep = '{4'b1000};
        exp_q.push_back(mk(32'hCCDDEE99, 4'hF, 1'b1));
        run_packet(3'd3, 32'h00CCDDEE, 4'b0111, 1'b0);
        drain("ex041");

        gen_payload(3, 1'b0);
        run_packet(3'd0, 32'd0, 4'd0, 1'b1);
        pw_data = '{$urandom};
        pw_keep = '{4'hF};
        run_packet(3'd4, 32'hA1A2A3A4, 4'hF, 1'b1);
        drain("ex042");

        // Downstream stall mid-packet.
        gen_payload(4, 1'b0);
        pw_keep[3] = 4'hF;
        beats_acc = 0;
        fork
            run_packet(3'd0, 32'd0, 4'd0, 1'b1);
            begin
                for (int c = 0; c < 300; c++) begin
                    @(negedge clk);
                    if (beats_acc >= 2) break;
                end
                bp_mode = 2;
                @(posedge clk);
                #2;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check_val("stall_ready_in", {63'd0, bus.ready_in}, 64'd0);
                    check_val("stall_valid_out", {63'd0, bus.valid_out}, 64'd1);
                    if (exp_q.size() > 0)
                        check_val("stall_data_out", {32'd0, bus.data_out}, {32'd0, exp_q[0].d});
                end
                bp_mode = 0;
            end
        join
        drain("ex043");

        // Reset while a residue is pending, then a clean 1-byte-header packet.
        exp_q.push_back(mk(32'hAABB1122, 4'hF, 1'b0));
        send_header(3'd2, 32'h0000AABB, 4'b0011);
        drive_beat(32'h11223344, 4'hF, 1'b0);
        apply_reset();
        gen_payload(2, 1'b0);
        run_packet(3'd1, 32'h000000C5, 4'b0001, 1'b1);
        drain("ex045");

        bp_mode = 1;
        for (int p = 0; p < 20; p++) random_packet();
        drain("rand_a");

        // Inconsistent header keep, then an over-range count, then clean traffic.
        gen_payload(2, 1'b0);
        run_packet(3'd2, $urandom, 4'b0001, 1'b1);
        drain("ex044");
        gen_payload(2, 1'b0);
        run_packet(3'd6, $urandom, 4'hF, 1'b1);
        for (int p = 0; p < 10; p++) random_packet();
        drain("rand_b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axis_hdr_insert_pack.md
AXIS_HDR_INSERT_PACK -- requirements
Module: axis_hdr_insert_pack

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, meaning data width in bits; must be a multiple of 8 and at least 16.
REQ-002 SHALL have parameter DATA_BYTE_WD, default DATA_WD/8, meaning bytes per beat (W).
REQ-003 SHALL have parameter BYTE_CNT_WD, default $clog2(DATA_BYTE_WD+1), meaning header byte-count width, covering 0..W.
REQ-004 SHALL provide ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_in  in  1  input stream valid.
- data_in  in  DATA_WD  input data; byte 0 is data_in[DATA_WD-1 -: 8].
- keep_in  in  DATA_BYTE_WD  byte enables, MSB-aligned and contiguous.
- last_in  in  1  final beat of packet.
- ready_in  out  1  input stream ready.
- valid_out  out  1  output stream valid.
- data_out  out  DATA_WD  output data, byte order as data_in.
- keep_out  out  DATA_BYTE_WD  output byte enables, MSB-aligned.
- last_out  out  1  final output beat.
- ready_out  in  1  downstream ready.
- valid_insert  in  1  header valid.
- ready_insert  out  1  header ready (new vs. previous generation).
- data_insert  in  DATA_WD  header; valid bytes are the low H bytes.
- keep_insert  in  DATA_BYTE_WD  header enables, expected = low H bits set.
- byte_insert_cnt  in  BYTE_CNT_WD  header byte count H, 0..W.
- hdr_err  out  1  sticky flag: keep_insert inconsistent with byte_insert_cnt.
- pkt_cnt  out  16  count of packets completed on output.

Function
REQ-010 States SHALL be IDLE, STREAM and FLUSH, with IDLE after reset.
REQ-011 ready_insert SHALL be 1 exactly in IDLE; ready_in SHALL be 1 exactly when state is STREAM and (!valid_out || ready_out).
REQ-012 Header acceptance (IDLE, valid_insert & ready_insert) SHALL load residue bytes = low H bytes of data_insert and residue count R=H, and go to STREAM.
REQ-013 H=0 SHALL give pure pass-through of the packet with 1-cycle latency; H>W SHALL be clamped to W and set hdr_err.
REQ-014 On each accepted input beat with N = popcount(keep_in), the block SHALL form stream S = residue(R bytes) followed by input(N bytes) and load the output register with:
- if R+N >= W: the first W bytes of S, keep_out all ones; residue becomes the remaining R+N-W bytes.
- else: S, keep_out = top R+N bits set.
REQ-015 For a non-last beat, N SHALL be W. A non-last beat with keep_in not all ones is a protocol error and output is unspecified.
REQ-016 For a last beat, if R+N <= W the block SHALL emit S with last_out=1 and go to IDLE; if R+N > W it SHALL emit W bytes with last_out=0 and go to FLUSH.
REQ-017 In FLUSH, when !valid_out || ready_out, the block SHALL emit the residue (R+N-W bytes, MSB-aligned, zero-padded) with last_out=1 and go to IDLE.
REQ-018 A last beat with keep_in=0 and R=0 SHALL be forwarded as a null beat: keep_out=0, last_out=1.
REQ-019 The output register SHALL hold data_out, keep_out and last_out stable while valid_out & !ready_out; valid_out SHALL clear only on handshake with no new load.
REQ-020 Within a packet, sustained throughput SHALL be one beat per cycle when ready_out=1; one idle input cycle between packets (header cycle) is allowed.
REQ-021 Invalid bytes of data_out SHALL be zero.
REQ-022 hdr_err SHALL set on a header handshake where keep_insert != (2^H)-1, and SHALL clear only on reset.
REQ-023 pkt_cnt SHALL increment on each output handshake with last_out=1 and wrap at 16'hFFFF -> 0.

Reset
REQ-030 rst_n low SHALL asynchronously force: state=IDLE, valid_out=0, data_out=0, keep_out=0, last_out=0, R=0, hdr_err=0, pkt_cnt=0.
REQ-031 Reset mid-packet SHALL discard the residue and partial packet; after release the block SHALL wait for a new header.

Verification
REQ-040 DATA_WD=32, H=2, data_insert=0x0000AABB, keep_insert=0011; packet 0x11223344, 0x55667788 (keep 1111, last) -> output 0xAABB1122/1111, 0x33445566/1111, 0x77880000/1100 with last; pkt_cnt=1.
REQ-041 H=3, data_insert=0x00CCDDEE; single beat 0x99000000, keep 1000, last -> one beat 0xCCDDEE99, keep 1111, last; no FLUSH.
REQ-042 H=0; 3-beat packet -> identical beats at 1-cycle latency; H=4 (data_insert=0xA1A2A3A4) with a 1-beat packet -> two output beats, the second being the input beat with last.
REQ-043 ready_out held low 3 cycles mid-packet -> data_out stable, ready_in=0, no byte lost or duplicated.
REQ-044 H=2, keep_insert=0001 -> hdr_err=1, which stays set through later clean packets.
REQ-045 rst_n asserted in STREAM with residue pending -> all outputs 0 immediately; next packet (H=1) is output correctly.
